// File: rtl/sdram_port_arbiter_if.sv
// Controller-side bus of the SDRAM port arbiter: one write port and one read port,
// each with a req/ack handshake, burst start address and burst length.
interface sdram_port_arbiter_if #(
   parameter int ADDR_W = 21,
   parameter int LEN_W  = 9,
   parameter int DATA_W = 32
);
   logic              sdram_wr_req;
   logic              sdram_wr_ack;
   logic [ADDR_W-1:0] sdram_wr_addr;
   logic [LEN_W-1:0]  sdram_wr_burst;
   logic [DATA_W-1:0] sdram_din;
   logic              sdram_rd_req;
   logic              sdram_rd_ack;
   logic [ADDR_W-1:0] sdram_rd_addr;
   logic [LEN_W-1:0]  sdram_rd_burst;
   logic [DATA_W-1:0] sdram_dout;

   modport master (
      output sdram_wr_req, sdram_wr_addr, sdram_wr_burst, sdram_din,
      output sdram_rd_req, sdram_rd_addr, sdram_rd_burst,
      input  sdram_wr_ack, sdram_rd_ack, sdram_dout
   );

   modport slave (
      input  sdram_wr_req, sdram_wr_addr, sdram_wr_burst, sdram_din,
      input  sdram_rd_req, sdram_rd_addr, sdram_rd_burst,
      output sdram_wr_ack, sdram_rd_ack, sdram_dout
   );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Round-robin front end multiplexing NUM_CH write and NUM_CH read channels onto the
// single write and read ports of sdram_controller, with per-channel wrapping pointers.
module sdram_port_arbiter #(
   parameter int NUM_CH = 2,
   parameter int ADDR_W = 21,
   parameter int LEN_W  = 9,
   parameter int DATA_W = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       sdram_init_done,
   input  logic [NUM_CH-1:0]          ch_wr_need,
   input  logic [NUM_CH-1:0]          ch_rd_need,
   input  logic [NUM_CH-1:0]          ch_rd_valid,
   input  logic [NUM_CH-1:0]          ch_wr_load,
   input  logic [NUM_CH-1:0]          ch_rd_load,
   input  logic [NUM_CH*ADDR_W-1:0]   ch_wr_base,
   input  logic [NUM_CH*ADDR_W-1:0]   ch_wr_end,
   input  logic [NUM_CH*ADDR_W-1:0]   ch_rd_base,
   input  logic [NUM_CH*ADDR_W-1:0]   ch_rd_end,
   input  logic [NUM_CH*LEN_W-1:0]    ch_wr_len,
   input  logic [NUM_CH*LEN_W-1:0]    ch_rd_len,
   input  logic [NUM_CH*DATA_W-1:0]   ch_wr_data,
   output logic [NUM_CH-1:0]          ch_wr_pop,
   output logic [NUM_CH-1:0]          ch_rd_push,
   output logic [DATA_W-1:0]          ch_rd_data,
   output logic [$clog2(2*NUM_CH):0]  grant_slot,
   sdram_port_arbiter_if.master       sdram
);
   localparam int SLOTS = 2 * NUM_CH;
   localparam int GW    = $clog2(SLOTS) + 1;

   typedef enum logic [2:0] {IDLE, WR_REQ, WR_XFER, RD_REQ, RD_XFER, DONE} state_t;

   state_t            state, state_nxt;
   logic              init_d;
   logic              init_rise;
   logic [ADDR_W-1:0] wr_ptr [NUM_CH];
   logic [ADDR_W-1:0] rd_ptr [NUM_CH];
   logic [GW-1:0]     last_grant;
   logic [SLOTS-1:0]  elig;
   logic              found;
   logic [GW-1:0]     pick;
   logic              pick_rd;
   logic [ADDR_W-1:0] g_addr, g_base, g_end;
   logic [LEN_W-1:0]  g_len;
   logic [ADDR_W-1:0] cur_addr, cur_base, cur_end;
   logic [LEN_W-1:0]  cur_len;
   logic              discard;
   logic              active_load;
   logic [ADDR_W:0]   nxt_sum;
   logic [ADDR_W-1:0] upd_ptr;

   assign init_rise = sdram_init_done & ~init_d;
   assign pick_rd   = (pick >= GW'(NUM_CH));

   always_comb begin
      elig = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         elig[i]        = sdram_init_done & ch_wr_need[i] & (|ch_wr_len[i*LEN_W +: LEN_W]) & ~ch_wr_load[i];
         elig[NUM_CH+i] = sdram_init_done & ch_rd_need[i] & ch_rd_valid[i] &
                          (|ch_rd_len[i*LEN_W +: LEN_W]) & ~ch_rd_load[i];
      end
   end

   // Search order starts one slot past the previous winner and wraps around.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      for (int k = 0; k < SLOTS; k++) begin
         for (int j = 0; j < SLOTS; j++) begin
            if (!found && elig[j] && (j == (int'(last_grant) + 1 + k) % SLOTS)) begin
               found = 1'b1;
               pick  = GW'(j);
            end
         end
      end
   end

   // A pointer reloaded by the init rising edge this cycle is still stale, so use base.
   always_comb begin
      g_addr = '0;
      g_base = '0;
      g_end  = '0;
      g_len  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (pick == GW'(i)) begin
            g_base = ch_wr_base[i*ADDR_W +: ADDR_W];
            g_end  = ch_wr_end[i*ADDR_W +: ADDR_W];
            g_len  = ch_wr_len[i*LEN_W +: LEN_W];
            g_addr = init_rise ? ch_wr_base[i*ADDR_W +: ADDR_W] : wr_ptr[i];
         end
         if (pick == GW'(NUM_CH + i)) begin
            g_base = ch_rd_base[i*ADDR_W +: ADDR_W];
            g_end  = ch_rd_end[i*ADDR_W +: ADDR_W];
            g_len  = ch_rd_len[i*LEN_W +: LEN_W];
            g_addr = init_rise ? ch_rd_base[i*ADDR_W +: ADDR_W] : rd_ptr[i];
         end
      end
   end

   always_comb begin
      active_load = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if ((grant_slot == GW'(i) && ch_wr_load[i]) ||
             (grant_slot == GW'(NUM_CH + i) && ch_rd_load[i]))
            active_load = 1'b1;
      end
   end

   always_comb begin
      nxt_sum = {1'b0, cur_addr} + (ADDR_W+1)'(cur_len);
      upd_ptr = ((nxt_sum + (ADDR_W+1)'(cur_len)) > {1'b0, cur_end}) ? cur_base : nxt_sum[ADDR_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         init_d <= 1'b0;
      end else begin
         state  <= state_nxt;
         init_d <= sdram_init_done;
      end
   end

   always_comb begin
      state_nxt          = state;
      sdram.sdram_wr_req = 1'b0;
      sdram.sdram_rd_req = 1'b0;
      unique case (state)
         IDLE:    if (found) state_nxt = pick_rd ? RD_REQ : WR_REQ;
         WR_REQ: begin
            sdram.sdram_wr_req = 1'b1;
            if (sdram.sdram_wr_ack) state_nxt = WR_XFER;
         end
         WR_XFER: if (!sdram.sdram_wr_ack) state_nxt = DONE;
         RD_REQ: begin
            sdram.sdram_rd_req = 1'b1;
            if (sdram.sdram_rd_ack) state_nxt = RD_XFER;
         end
         RD_XFER: if (!sdram.sdram_rd_ack) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // A load or init edge seen while a burst is in flight voids that burst's pointer advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_slot           <= '1;
         last_grant           <= GW'(SLOTS - 1);
         sdram.sdram_wr_addr  <= '0;
         sdram.sdram_wr_burst <= '0;
         sdram.sdram_rd_addr  <= '0;
         sdram.sdram_rd_burst <= '0;
         cur_addr             <= '0;
         cur_base             <= '0;
         cur_end              <= '0;
         cur_len              <= '0;
         discard              <= 1'b0;
      end else if (state == IDLE) begin
         if (found) begin
            grant_slot <= pick;
            last_grant <= pick;
            cur_addr   <= g_addr;
            cur_base   <= g_base;
            cur_end    <= g_end;
            cur_len    <= g_len;
            discard    <= 1'b0;
            if (pick_rd) begin
               sdram.sdram_rd_addr  <= g_addr;
               sdram.sdram_rd_burst <= g_len;
            end else begin
               sdram.sdram_wr_addr  <= g_addr;
               sdram.sdram_wr_burst <= g_len;
            end
         end
      end else begin
         if (active_load || init_rise) discard <= 1'b1;
         if (state == DONE) grant_slot <= '1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (init_rise || ch_wr_load[i])
               wr_ptr[i] <= ch_wr_base[i*ADDR_W +: ADDR_W];
            else if (state == DONE && !discard && grant_slot == GW'(i))
               wr_ptr[i] <= upd_ptr;
            if (init_rise || ch_rd_load[i])
               rd_ptr[i] <= ch_rd_base[i*ADDR_W +: ADDR_W];
            else if (state == DONE && !discard && grant_slot == GW'(NUM_CH + i))
               rd_ptr[i] <= upd_ptr;
         end
      end
   end

   always_comb begin
      ch_wr_pop       = '0;
      ch_rd_push      = '0;
      sdram.sdram_din = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (grant_slot == GW'(i)) begin
            ch_wr_pop[i]    = sdram.sdram_wr_ack;
            sdram.sdram_din = ch_wr_data[i*DATA_W +: DATA_W];
         end
         if (grant_slot == GW'(NUM_CH + i))
            ch_rd_push[i] = sdram.sdram_rd_ack;
      end
   end

   assign ch_rd_data = sdram.sdram_dout;

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Parametrised multi-channel front end for `sdram_controller`. It multiplexes NUM_CH independent write channels and NUM_CH independent read channels onto the controller's single write port and single read port. Each channel has its own address region with wrap, its own burst length and its own load (pointer reset). It sits between the per-channel FIFO controllers and `sdram_controller`, all in the SDRAM reference clock domain. It replaces the fixed single-write/single-read address generation.

## Interface
- NUM_CH, 2: number of write channels and number of read channels; 1..8.
- ADDR_W, 21: SDRAM word address width.
- LEN_W, 9: burst length width.
- DATA_W, 32: SDRAM data width.

- clk  in  1  controller clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sdram_init_done  in  1  controller initialisation complete.
- ch_wr_need  in  NUM_CH  channel i write FIFO holds at least one burst.
- ch_rd_need  in  NUM_CH  channel i read FIFO has room for one burst.
- ch_rd_valid  in  NUM_CH  channel i read enable.
- ch_wr_load, ch_rd_load  in  NUM_CH  pointer reset to base, one pulse or level.
- ch_wr_base, ch_wr_end, ch_rd_base, ch_rd_end  in  NUM_CH*ADDR_W  region bounds; channel i occupies slice [i*ADDR_W +: ADDR_W]; end is exclusive.
- ch_wr_len, ch_rd_len  in  NUM_CH*LEN_W  burst length per channel.
- ch_wr_data  in  NUM_CH*DATA_W  write FIFO head words.
- ch_wr_pop  out  NUM_CH  write FIFO read strobe.
- ch_rd_push  out  NUM_CH  read FIFO write strobe.
- ch_rd_data  out  DATA_W  read data, common to all channels.
- grant_slot  out  $clog2(2*NUM_CH)+1  current owner; all-ones when idle.
- sdram_wr_req / sdram_rd_req  out  1  requests to the controller.
- sdram_wr_ack / sdram_rd_ack  in  1  controller acknowledges.
- sdram_wr_addr / sdram_rd_addr  out  ADDR_W  burst start address.
- sdram_wr_burst / sdram_rd_burst  out  LEN_W  burst length.
- sdram_din  out  DATA_W  write data.
- sdram_dout  in  DATA_W  read data.

## Operation
- Slots: 0..NUM_CH-1 are write channel i; NUM_CH..2*NUM_CH-1 are read channel i.
- Eligibility, evaluated while the arbiter is in IDLE:
  - Write slot: sdram_init_done & ch_wr_need[i] & len≠0 & !ch_wr_load[i].
  - Read slot: the same, using ch_rd_need, ch_rd_valid and ch_rd_load.
- Round-robin arbitration: search from (last_grant+1) mod 2*NUM_CH. last_grant resets to 2*NUM_CH-1, so slot 0 wins first.
- FSM states: IDLE, WR_REQ, WR_XFER, RD_REQ, RD_XFER, DONE.
  - IDLE→WR_REQ or RD_REQ when any slot is eligible. The grant, address and burst length are latched in the same clock edge.
  - In WR_REQ/RD_REQ the matching req is high. The FSM moves to WR_XFER/RD_XFER on the first cycle with ack=1.
  - In XFER the FSM moves to DONE on the first cycle with ack=0.
  - DONE→IDLE.
- Data path, combinational on ack:
  - Write: ch_wr_pop[g] = sdram_wr_ack while grant is write slot g; sdram_din = ch_wr_data slice g.
  - Read: ch_rd_push[g] = sdram_rd_ack while grant is read slot g; ch_rd_data = sdram_dout.
  - All other pop/push bits are 0.
- Pointer update in DONE, using 22-bit-safe arithmetic (ADDR_W+1 bits): nxt = ptr + len. If nxt + len > end, ptr ← base; else ptr ← nxt.
- Load rules:
  - ch_*_load[i] sets ptr_i ← base_i on the next edge.
  - A load overrides a DONE update for the same channel in the same cycle.
  - A load during that channel's active burst does not abort the burst; its end-of-burst advance is discarded.
- A rising edge of sdram_init_done loads every pointer with its base.
- sdram_init_done falling during a burst: the burst completes; no new grants are issued.
- Base, end and len are sampled only at grant. Changes mid-burst take effect at the next grant.

## Timing
- Reset values: sdram_wr_req=0, sdram_rd_req=0, all addr/burst=0, pop=push=0, grant_slot=all-ones, all pointers=0, FSM=IDLE, last_grant=2*NUM_CH-1.
- need→req latency: 1 cycle. Eligible in IDLE at edge n; req high after edge n.
- req is registered and falls on the edge after the first ack=1 is sampled. The controller must tolerate req high for one cycle of ack.
- Back-to-back bursts: minimum 2 idle cycles between ack falling and the next req (DONE, IDLE).
- Simultaneous write and read needs on the same channel are ordered by the slot index rotation only; no write priority.

## Test plan
- NUM_CH=2, only ch0 write: len=8, base=0, end=32, 5 bursts. Required addresses 0, 8, 16, 24, 0; 8 pops per burst; req rises 1 cycle after need.
- All 4 slots permanently eligible. Required grant order 0, 1, 2, 3, 0, …; each read burst has 4 pushes routed only to its channel; ch_rd_data equals sdram_dout.
- ch1 read with len=5, base=100, end=112. Required addresses 100, 105, then 100, since 110+5 > 112.
- Pulse ch0 write load mid-burst at ptr 16. The burst finishes with 8 pops; the next burst address is base 0, not 24.
- Assert rst_n=0 mid WR_XFER. Outputs immediately take reset values. After release with sdram_init_done rising, pointers equal their bases.
- len=0 on ch0 while need=1. ch0 is never granted; other slots are served normally.
